// File: rtl/cdivider.sv
// Sequential complex divider q = a / b: forms a*conj(b) and |b|^2, then runs two
// restoring dividers (real/imag) in lockstep, one quotient bit per clock.
module cdivider #(
   parameter int W    = 16,
   parameter int FRAC = 14,
   parameter int QW   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] ar,
   input  logic signed [W-1:0] ai,
   input  logic signed [W-1:0] br,
   input  logic signed [W-1:0] bi,
   output logic                out_valid,
   output logic [QW-1:0]       qr,
   output logic [QW-1:0]       qi,
   output logic                dz,
   output logic                sat
);

   localparam int N  = 2*W + FRAC;
   localparam int CW = $clog2(N);
   localparam int DW = 2*W;
   localparam int NW = 2*W + 1;
   localparam logic [CW-1:0] LAST = CW'(N-1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

   state_t state_reg, state_next;

   logic signed [W-1:0] ar_reg, ai_reg, br_reg, bi_reg;
   logic [DW-1:0]       d_reg;
   logic                zero_d_reg;
   logic [CW-1:0]       cnt_reg;

   logic [1:0][NW-1:0]  n_c;
   logic signed [DW-1:0] br_sq, bi_sq;
   logic [DW-1:0]       d_c;
   logic [1:0][QW-1:0]  res_c;
   logic [1:0]          sat_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid) state_next = MUL;
         MUL:     state_next = DIV;
         DIV:     if (cnt_reg == LAST) state_next = FIN;
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready = (state_reg == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_reg <= '0;
         ai_reg <= '0;
         br_reg <= '0;
         bi_reg <= '0;
      end else if (in_valid && in_ready) begin
         ar_reg <= ar;
         ai_reg <= ai;
         br_reg <= br;
         bi_reg <= bi;
      end
   end

   // a*conj(b) needs 2W+1 bits; |b|^2 <= 2^31 fits 2W bits unsigned even though it wraps as signed.
   always_comb begin
      n_c[0] = NW'(ar_reg) * NW'(br_reg) + NW'(ai_reg) * NW'(bi_reg);
      n_c[1] = NW'(ai_reg) * NW'(br_reg) - NW'(ar_reg) * NW'(bi_reg);
      br_sq  = DW'(br_reg) * DW'(br_reg);
      bi_sq  = DW'(bi_reg) * DW'(bi_reg);
      d_c    = br_sq + bi_sq;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_reg      <= '0;
         zero_d_reg <= 1'b0;
         cnt_reg    <= '0;
      end else if (state_reg == MUL) begin
         d_reg      <= d_c;
         zero_d_reg <= (d_c == '0);
         cnt_reg    <= '0;
      end else if (state_reg == DIV) begin
         cnt_reg    <= cnt_reg + 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_div
         logic          sign_reg;
         logic [DW-1:0] mag_reg;
         logic [DW-1:0] rem_reg;
         logic [N-1:0]  quo_reg;
         logic [DW:0]   trial;
         logic          ge;
         logic [QW-2:0] qmag;

         // mag_reg shifts out MSB-first; once empty it feeds the FRAC trailing zeros.
         assign trial = {rem_reg, mag_reg[DW-1]};
         assign ge    = (trial >= {1'b0, d_reg});

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sign_reg <= 1'b0;
               mag_reg  <= '0;
               rem_reg  <= '0;
               quo_reg  <= '0;
            end else if (state_reg == MUL) begin
               sign_reg <= n_c[gi][DW];
               mag_reg  <= n_c[gi][DW] ? (~n_c[gi][DW-1:0] + 1'b1) : n_c[gi][DW-1:0];
               rem_reg  <= '0;
               quo_reg  <= '0;
            end else if (state_reg == DIV) begin
               mag_reg  <= mag_reg << 1;
               rem_reg  <= ge ? DW'(trial - {1'b0, d_reg}) : trial[DW-1:0];
               quo_reg  <= {quo_reg[N-2:0], ge};
            end
         end

         assign sat_c[gi] = |quo_reg[N-1:QW-1];
         assign qmag      = sat_c[gi] ? {(QW-1){1'b1}} : quo_reg[QW-2:0];
         assign res_c[gi] = sign_reg ? -{1'b0, qmag} : {1'b0, qmag};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         qr        <= '0;
         qi        <= '0;
         dz        <= 1'b0;
         sat       <= 1'b0;
      end else begin
         out_valid <= (state_reg == FIN);
         if (state_reg == FIN) begin
            dz  <= zero_d_reg;
            qr  <= zero_d_reg ? '0 : res_c[0];
            qi  <= zero_d_reg ? '0 : res_c[1];
            sat <= !zero_d_reg && (|sat_c);
         end
      end
   end

endmodule

// File: tb/tb_cdivider.sv
// Randomized bench for cdivider: each result is compared with an arithmetic
// reference (complex division by plain integer maths), plus handshake and reset checks.
module tb_cdivider;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] ar, ai, br, bi;
   logic               out_valid;
   logic signed [15:0] qr, qi;
   logic               dz, sat;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cdivider #(.W(16), .FRAC(14), .QW(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ar(ar), .ai(ai), .br(br), .bi(bi),
      .out_valid(out_valid), .qr(qr), .qi(qi), .dz(dz), .sat(sat)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // q = a*conj(b)/|b|^2 scaled by 2^14, truncated toward zero, clamped symmetrically.
   function automatic void ref_div(input longint xar, xai, xbr, xbi,
                                   output longint eqr, eqi, output bit edz, esat);
      longint num [2];
      longint d, q;
      longint res [2];
      num[0] = xar*xbr + xai*xbi;
      num[1] = xai*xbr - xar*xbi;
      d = xbr*xbr + xbi*xbi;
      edz = (d == 0);
      esat = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (d == 0) q = 0;
         else q = (num[k] * 16384) / d;
         if (q > 32767)  begin q = 32767;  esat = 1'b1; end
         if (q < -32767) begin q = -32767; esat = 1'b1; end
         res[k] = q;
      end
      eqr = res[0];
      eqi = res[1];
   endfunction

   function automatic int rnd16();
      logic signed [15:0] v;
      v = 16'($urandom);
      return int'(v);
   endfunction

   // Called and returns on a negedge. hold keeps in_valid high (garbage) while busy;
   // noise injects an in_valid pulse mid-division.
   task automatic run_op(input int xar, xai, xbr, xbi, input bit hold, input bit noise);
      int     guard, lat;
      bit     busy_ready;
      longint eqr, eqi;
      bit     edz, esat;
      ref_div(xar, xai, xbr, xbi, eqr, eqi, edz, esat);
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("idle_ready", in_ready, 1);
      ar = 16'(xar); ai = 16'(xai); br = 16'(xbr); bi = 16'(xbi);
      in_valid = 1'b1;
      @(negedge clk);
      lat = 1;
      busy_ready = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready) busy_ready = 1'b1;
         in_valid = hold || (noise && lat >= 20 && lat <= 22);
         if (in_valid) begin
            ar = 16'($urandom); ai = 16'($urandom); br = 16'($urandom); bi = 16'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 49);
      check("busy_ready", busy_ready, 0);
      check("strobe_ready", in_ready, 1);
      check("qr", qr, eqr);
      check("qi", qi, eqi);
      check("dz", dz, edz);
      check("sat", sat, esat);
      $display("op a=(%0d,%0d) b=(%0d,%0d) -> q=(%0d,%0d) dz=%0b sat=%0b lat=%0d exp=(%0d,%0d)",
               xar, xai, xbr, xbi, qr, qi, dz, sat, lat, eqr, eqi);
      if (!hold) begin
         in_valid = 1'b0;
         @(negedge clk);
         check("strobe_len", out_valid, 0);
         check("hold_qr", qr, eqr);
         check("hold_qi", qi, eqi);
      end
   endtask

   initial begin
      bit seen;
      int xar, xai, xbr, xbi;
      rst_n = 1'b0;
      in_valid = 1'b0;
      ar = '0; ai = '0; br = '0; bi = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", in_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_qr", qr, 0);
      check("rst_qi", qi, 0);
      check("rst_dz", dz, 0);
      check("rst_sat", sat, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors from the datasheet plus the extreme operand.
      run_op(16384, 0, 16384, 0, 0, 0);
      run_op(1, 2, 3, 4, 0, 0);
      run_op(-1, -2, 3, 4, 0, 1);
      run_op(0, 1000, 1000, 0, 0, 0);
      run_op(3, 4, 1, 2, 0, 0);
      run_op(500, -7, 0, 0, 0, 1);
      run_op(-32768, -32768, -32768, -32768, 0, 0);

      // Back-to-back with in_valid held high.
      run_op(100, -200, 7, 9, 1, 0);
      run_op(-5000, 3000, 4000, -1234, 1, 0);
      run_op(32767, -32768, -1, 1, 1, 0);
      run_op(12, 34, 56, 78, 0, 0);

      // Randomized operands, mixing small, full-range and zero divisors.
      for (int i = 0; i < 24; i++) begin
         if (i % 3 == 0) begin
            xar = int'($urandom_range(0, 2000)) - 1000;
            xai = int'($urandom_range(0, 2000)) - 1000;
            xbr = int'($urandom_range(0, 2000)) - 1000;
            xbi = int'($urandom_range(0, 2000)) - 1000;
         end else begin
            xar = rnd16(); xai = rnd16(); xbr = rnd16(); xbi = rnd16();
         end
         if (i % 8 == 7) begin
            xbr = 0; xbi = 0;
         end
         run_op(xar, xai, xbr, xbi, (i % 4 == 1), (i % 5 == 2));
      end

      // Reset in the middle of DIV: result discarded, outputs cleared.
      run_op(1, 2, 3, 4, 0, 0);
      ar = 16'(7000); ai = 16'(-300); br = 16'(900); bi = 16'(41);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (22) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_qr", qr, 0);
      check("midrst_qi", qi, 0);
      check("midrst_dz", dz, 0);
      check("midrst_sat", sat, 0);
      check("midrst_ready", in_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("no_strobe_after_rst", seen, 0);
      run_op(7000, -300, 900, 41, 0, 0);
      run_op(-32768, -32768, -32768, -32768, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
